load_hazard_stall_unit: RTL
===========================

// Module: load_hazard_stall_unit
// PURPOSE
//  Stall/flush controller beside the ALU forwarding logic. Forwarding cannot cover a load
//  whose data is needed by the very next instruction. It cannot cover a data-memory busywait
//  or a taken branch either. This block detects those cases and drives the PC, IF/ID and
//  ID/EX pipeline-register controls. It also keeps stall statistics and a busywait watchdog.
// PARAMETERS
//  COUNT_WIDTH    32   width of stall_cycle_count / load_stall_count (saturating)
//  TIMEOUT_CYCLES 64   consecutive busywait cycles before mem_timeout_error sets
// PORTS
//  clk                    in   1  system clock, all state on posedge
//  reset                  in   1  synchronous, active-high
//  mem_read_alu_stage     in   1  instruction in ALU stage is a load
//  rd_address_alu_stage   in   5  destination register of ALU-stage instruction
//  rs1_address_id_stage   in   5  rs1 of ID-stage instruction
//  rs2_address_id_stage   in   5  rs2 of ID-stage instruction
//  rs1_used_id_stage      in   1  ID instruction reads rs1
//  rs2_used_id_stage      in   1  ID instruction reads rs2
//  data_mem_busywait      in   1  data memory not ready; whole pipeline must freeze
//  branch_taken_alu_stage in   1  branch/jump resolved taken in ALU stage
//  pc_write_enable        out  1  0 = hold PC
//  if_id_write_enable     out  1  0 = hold IF/ID register
//  id_ex_write_enable     out  1  0 = hold ID/EX register (freeze)
//  id_ex_bubble           out  1  1 = load NOP into ID/EX
//  if_id_flush            out  1  1 = load NOP into IF/ID
//  stall_cycle_count      out  COUNT_WIDTH  cycles with any hold/bubble asserted
//  load_stall_count       out  COUNT_WIDTH  load-use bubbles inserted
//  mem_timeout_error      out  1  sticky watchdog flag
// BEHAVIOUR
//  - Reset (sync): state=RUN, counters=0, mem_timeout_error=0, watchdog=0. While reset is
//    high, the outputs are: write enables 1, id_ex_bubble 1, if_id_flush 1.
//  - Control outputs are Mealy: combinational from the registered state and current inputs.
//    Counters and the error flag are registered.
//  - load_use = mem_read_alu_stage & rd_alu!=0 & ((rs1_used & rs1==rd_alu) | (rs2_used & rs2==rd_alu)).
//  - Priority per cycle: busywait > pending/actual flush > load_use > none.
//  - States: RUN, MEM_WAIT, MEM_WAIT_FLUSH (flush captured during a freeze).
//  - RUN, busywait=1: all write enables 0, no bubble/flush. Next state is MEM_WAIT, or
//    MEM_WAIT_FLUSH if branch_taken=1.
//  - RUN, branch_taken=1: if_id_flush=1, id_ex_bubble=1, enables 1. load_use is ignored
//    (squashed instruction) and not counted.
//  - RUN, load_use=1: pc/if_id enables 0, id_ex_bubble=1. load_stall_count+1. Stay in RUN.
//    The load advances to MEM, so the hazard clears after 1 cycle; no state is needed.
//  - MEM_WAIT/MEM_WAIT_FLUSH, busywait=1: freeze as above.
//    branch_taken=1 in MEM_WAIT moves to MEM_WAIT_FLUSH.
//  - Busywait falls in MEM_WAIT: evaluate the RUN rules this cycle, next state RUN.
//  - Busywait falls in MEM_WAIT_FLUSH: force flush this cycle, regardless of the current
//    branch_taken. Next state RUN.
//  - Watchdog counts consecutive busywait cycles and clears when busywait=0. Reaching
//    TIMEOUT_CYCLES sets mem_timeout_error; only reset clears it. The freeze continues.
//  - stall_cycle_count +1 whenever any of pc/if_id/id_ex enable=0 or id_ex_bubble=1
//    (not a pure flush). Both counters saturate at all-ones and never wrap.
//  - Reset asserted mid-stall/mid-wait: the next cycle is RUN with counters 0. A pending
//    flush is discarded.
//  - rd_alu=x0 never causes a load-use stall.
// STRUCTURE
//  - Shared package: state encoding constants (RUN, MEM_WAIT, MEM_WAIT_FLUSH).
//    Also REG_ZERO=5'd0 and the NOP instruction constant used by the bubble/flush paths.
//  - One sub-module, sat_counter (parameterized width, inc, sync clear). Instantiated for
//    both statistics counters and the watchdog.
// TESTING
//  - lw x5 in ALU, ID add x6,x5,x7 (rs1_used=1) -> 1 cycle pc/if_id enable=0, bubble=1,
//    load_stall_count=1; next cycle all enables 1.
//  - lw x0 in ALU, ID rs1=x0 -> no stall. lw x5, ID rs2=x5 with rs2_used=0 -> no stall.
//  - busywait high 3 cycles -> enables 0 for exactly 3 cycles, stall_cycle_count=3.
//    Falling cycle has enables 1.
//  - busywait high, branch_taken pulse in cycle 2 of 4 -> no flush during the wait.
//    if_id_flush=1 and bubble=1 on the cycle busywait drops.
//  - branch_taken and load_use same cycle -> flush only, load_stall_count unchanged.
//  - TIMEOUT_CYCLES=4, busywait held 6 cycles -> error set at cycle 4 and stays set after
//    busywait drops. Reset clears it.

Source files
------------

// File: rtl/load_hazard_stall_unit_pkg.sv
// Shared constants for the load-use / busywait / branch stall controller.
package load_hazard_stall_unit_pkg;

  typedef enum logic [1:0] {
    StRun          = 2'd0,
    StMemWait      = 2'd1,
    StMemWaitFlush = 2'd2
  } state_e;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  // addi x0, x0, 0: the instruction a bubble or flush stands for.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/load_hazard_stall_unit_sat.sv
// Saturating up-counter with synchronous reset and clear.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/load_hazard_stall_unit.sv
// Drives PC / IF-ID / ID-EX controls for load-use stalls, busywait freezes and branch
// flushes, with stall statistics and a busywait watchdog.
module load_hazard_stall_unit
  import load_hazard_stall_unit_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH    = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_mem_read_alu_stage,
  input  logic [4:0]             i_rd_address_alu_stage,
  input  logic [4:0]             i_rs1_address_id_stage,
  input  logic [4:0]             i_rs2_address_id_stage,
  input  logic                   i_rs1_used_id_stage,
  input  logic                   i_rs2_used_id_stage,
  input  logic                   i_data_mem_busywait,
  input  logic                   i_branch_taken_alu_stage,
  output logic                   o_pc_write_enable,
  output logic                   o_if_id_write_enable,
  output logic                   o_id_ex_write_enable,
  output logic                   o_id_ex_bubble,
  output logic                   o_if_id_flush,
  output logic [COUNT_WIDTH-1:0] o_stall_cycle_count,
  output logic [COUNT_WIDTH-1:0] o_load_stall_count,
  output logic                   o_mem_timeout_error
);

  localparam int unsigned WdWidth = $clog2(TIMEOUT_CYCLES + 1);

  state_e             r_state;
  state_e             w_state_next;
  logic               w_load_use;
  logic               w_load_stall;
  logic               w_stall_cycle;
  logic               w_timeout_hit;
  logic [WdWidth-1:0] w_wd_count;
  logic               r_mem_timeout_error;

  assign w_load_use = i_mem_read_alu_stage && (i_rd_address_alu_stage != REG_ZERO) &&
                      ((i_rs1_used_id_stage && (i_rs1_address_id_stage == i_rd_address_alu_stage)) ||
                       (i_rs2_used_id_stage && (i_rs2_address_id_stage == i_rd_address_alu_stage)));

  always_comb begin
    o_pc_write_enable    = 1'b1;
    o_if_id_write_enable = 1'b1;
    o_id_ex_write_enable = 1'b1;
    o_id_ex_bubble       = 1'b0;
    o_if_id_flush        = 1'b0;
    w_load_stall         = 1'b0;
    w_state_next         = r_state;
    if (i_reset) begin
      o_id_ex_bubble = 1'b1;
      o_if_id_flush  = 1'b1;
      w_state_next   = StRun;
    end else if (i_data_mem_busywait) begin
      o_pc_write_enable    = 1'b0;
      o_if_id_write_enable = 1'b0;
      o_id_ex_write_enable = 1'b0;
      // A taken branch seen while frozen is remembered until the freeze ends.
      if (i_branch_taken_alu_stage || (r_state == StMemWaitFlush)) begin
        w_state_next = StMemWaitFlush;
      end else begin
        w_state_next = StMemWait;
      end
    end else begin
      w_state_next = StRun;
      if (i_branch_taken_alu_stage || (r_state == StMemWaitFlush)) begin
        o_id_ex_bubble = 1'b1;
        o_if_id_flush  = 1'b1;
      end else if (w_load_use) begin
        o_pc_write_enable    = 1'b0;
        o_if_id_write_enable = 1'b0;
        o_id_ex_bubble       = 1'b1;
        w_load_stall         = 1'b1;
      end
    end
  end

  // A flush also inserts a bubble but is not a stall.
  assign w_stall_cycle = !o_pc_write_enable || !o_if_id_write_enable || !o_id_ex_write_enable ||
                         (o_id_ex_bubble && !o_if_id_flush);

  assign w_timeout_hit = i_data_mem_busywait &&
                         (w_wd_count >= WdWidth'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state             <= StRun;
      r_mem_timeout_error <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_timeout_hit) begin
        r_mem_timeout_error <= 1'b1;
      end
    end
  end

  assign o_mem_timeout_error = r_mem_timeout_error;

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_stall_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (1'b0),
    .i_inc   (w_stall_cycle),
    .o_count (o_stall_cycle_count)
  );

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_load_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (1'b0),
    .i_inc   (w_load_stall),
    .o_count (o_load_stall_count)
  );

  sat_counter #(.WIDTH(WdWidth)) u_watchdog (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (!i_data_mem_busywait),
    .i_inc   (i_data_mem_busywait),
    .o_count (w_wd_count)
  );

endmodule
